regs_write_queue: RTL and testbench

//  Write-side companion to the register file. Buffers completed results in an
//  in-order queue and drains one per cycle onto the file's write port.

---
 rtl/regs_write_queue_if.sv | 67 ++++++
 rtl/regs_write_queue.sv | 149 ++++++++++++++
 tb/tb_regs_write_queue.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_write_queue_if.sv
// regs_write_queue_if
//  Bundles the producer side, the register-file write port and the two
//  forwarding read ports of the write queue.
//  Ports (all inside the interface):
//   enq_*            producer entry offer and enq_ready back-pressure
//   drain_en         write port available this cycle
//   isWrite..flagin  write port towards the register file
//   read1/2,isReg1/2 reader indices and bank selects
//   fwd*             forwarded pending values for the readers
//   count            occupied queue entries
//  Modports: slave = the queue itself, master = whoever drives the queue.
interface regs_write_queue_if #(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   parameter int AW    = 3
);
   logic                       enq_valid;
   logic                       enq_ready;
   logic                       enq_isWrite;
   logic                       enq_isRegW;
   logic [AW-1:0]              enq_reg;
   logic [DW-1:0]              enq_data;
   logic                       enq_wrFlip;
   logic                       enq_flip;
   logic                       enq_wrFlag;
   logic                       enq_flag;
   logic                       drain_en;
   logic                       isWrite;
   logic                       isRegW;
   logic [AW-1:0]              writeReg;
   logic [DW-1:0]              writeData;
   logic                       writeFlip;
   logic                       flipin;
   logic                       writeFlag;
   logic                       flagin;
   logic [AW-1:0]              read1;
   logic [AW-1:0]              read2;
   logic                       isReg1;
   logic                       isReg2;
   logic                       fwd1_hit;
   logic                       fwd2_hit;
   logic [DW-1:0]              fwd1_data;
   logic [DW-1:0]              fwd2_data;
   logic                       fwdFlip_hit;
   logic                       fwdFlip;
   logic                       fwdFlag_hit;
   logic                       fwdFlag;
   logic [$clog2(DEPTH):0]     count;

   modport slave (
      input  enq_valid, enq_isWrite, enq_isRegW, enq_reg, enq_data,
             enq_wrFlip, enq_flip, enq_wrFlag, enq_flag, drain_en,
             read1, read2, isReg1, isReg2,
      output enq_ready, isWrite, isRegW, writeReg, writeData, writeFlip,
             flipin, writeFlag, flagin, fwd1_hit, fwd2_hit, fwd1_data,
             fwd2_data, fwdFlip_hit, fwdFlip, fwdFlag_hit, fwdFlag, count
   );

   modport master (
      output enq_valid, enq_isWrite, enq_isRegW, enq_reg, enq_data,
             enq_wrFlip, enq_flip, enq_wrFlag, enq_flag, drain_en,
             read1, read2, isReg1, isReg2,
      input  enq_ready, isWrite, isRegW, writeReg, writeData, writeFlip,
             flipin, writeFlag, flagin, fwd1_hit, fwd2_hit, fwd1_data,
             fwd2_data, fwdFlip_hit, fwdFlip, fwdFlag_hit, fwdFlag, count
   );
endinterface

// File: rtl/regs_write_queue.sv
// regs_write_queue
//  In-order queue of completed results in front of the register file.
//  Drains one entry per cycle onto the file write port while forwarding
//  still-pending values to the two read ports (youngest match wins).
//  Ports:
//   CLK   rising-edge clock
//   RSTn  asynchronous active-low reset; discards every pending entry
//   bus   regs_write_queue_if.slave (producer, write port, read forwarding)
module regs_write_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   parameter int AW    = 3
) (
   input logic               CLK,
   input logic               RSTn,
   regs_write_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic          isWrite;
      logic          isRegW;
      logic [AW-1:0] rg;
      logic [DW-1:0] data;
      logic          wrFlip;
      logic          flip;
      logic          wrFlag;
      logic          flag;
   } entryT;

   entryT         entries [DEPTH];
   entryT         ordered [DEPTH];
   logic [DEPTH-1:0] live;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          doEnq;
   logic          doDrain;
   entryT         enqEntry;
   entryT         headEntry;

   // Regular-bank registers only decode the low two index bits, so aliases
   // such as 1 and 5 refer to the same register; the accumulator bank uses
   // the full index.
   function automatic logic matchRead(input entryT e, input logic [AW-1:0] rd,
                                      input logic isReg);
      logic idxEq;
      idxEq = isReg ? (e.rg[1:0] == rd[1:0]) : (e.rg == rd);
      return e.isWrite & (e.isRegW == isReg) & idxEq;
   endfunction

   assign bus.enq_ready = (count < CW'(DEPTH));
   assign bus.count     = count;
   assign doEnq         = bus.enq_valid & bus.enq_ready;
   assign doDrain       = (count != '0) & bus.drain_en;
   assign headEntry     = entries[head];

   assign enqEntry = '{isWrite: bus.enq_isWrite, isRegW: bus.enq_isRegW,
                       rg: bus.enq_reg, data: bus.enq_data,
                       wrFlip: bus.enq_wrFlip, flip: bus.enq_flip,
                       wrFlag: bus.enq_wrFlag, flag: bus.enq_flag};

   // Re-order storage by age: slot 0 is the head (oldest), higher slots are
   // younger; live marks slots that hold a pending entry.
   for (genvar k = 0; k < DEPTH; k++) begin : g_age
      assign ordered[k] = entries[head + PW'(k)];
      assign live[k]    = (CW'(k) < count);
   end

   // Queue storage and pointers. Enqueue and drain may happen in the same
   // cycle, in which case both pointers move and the count stays put.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         if (doEnq) begin
            entries[tail] <= enqEntry;
            tail          <= tail + PW'(1);
         end
         if (doDrain) begin
            head <= head + PW'(1);
         end
         count <= count + CW'(doEnq) - CW'(doDrain);
      end
   end

   // The head entry drives the file port directly; the file commits on the
   // same edge that pops it, so nothing is presented while idle.
   always_comb begin
      bus.isWrite   = 1'b0;
      bus.isRegW    = 1'b0;
      bus.writeReg  = '0;
      bus.writeData = '0;
      bus.writeFlip = 1'b0;
      bus.flipin    = 1'b0;
      bus.writeFlag = 1'b0;
      bus.flagin    = 1'b0;
      if (doDrain) begin
         bus.isWrite   = headEntry.isWrite;
         bus.isRegW    = headEntry.isRegW;
         bus.writeReg  = headEntry.rg;
         bus.writeData = headEntry.data;
         bus.writeFlip = headEntry.wrFlip;
         bus.flipin    = headEntry.flip;
         bus.writeFlag = headEntry.wrFlag;
         bus.flagin    = headEntry.flag;
      end
   end

   // Forwarding scans oldest to youngest so a later match overrides an
   // earlier one. The head still counts while it is being drained because
   // the file only sees its value at the coming edge.
   always_comb begin
      bus.fwd1_hit    = 1'b0;
      bus.fwd1_data   = '0;
      bus.fwd2_hit    = 1'b0;
      bus.fwd2_data   = '0;
      bus.fwdFlip_hit = 1'b0;
      bus.fwdFlip     = 1'b0;
      bus.fwdFlag_hit = 1'b0;
      bus.fwdFlag     = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (live[k]) begin
            if (matchRead(ordered[k], bus.read1, bus.isReg1)) begin
               bus.fwd1_hit  = 1'b1;
               bus.fwd1_data = ordered[k].data;
            end
            if (matchRead(ordered[k], bus.read2, bus.isReg2)) begin
               bus.fwd2_hit  = 1'b1;
               bus.fwd2_data = ordered[k].data;
            end
            if (ordered[k].wrFlip) begin
               bus.fwdFlip_hit = 1'b1;
               bus.fwdFlip     = ordered[k].flip;
            end
            if (ordered[k].wrFlag) begin
               bus.fwdFlag_hit = 1'b1;
               bus.fwdFlag     = ordered[k].flag;
            end
         end
      end
   end
endmodule

// File: tb/tb_regs_write_queue.sv
// tb_regs_write_queue
//  Drives regs_write_queue through directed scenarios and a random phase and
//  compares every output against a queue-based reference model each cycle.
//  Inputs change on the falling edge; outputs are sampled shortly after.
module tb_regs_write_queue;
   localparam int DEPTH = 4;
   localparam int DW    = 8;
   localparam int AW    = 3;

   typedef struct {
      bit isWrite;
      bit isRegW;
      int rg;
      int data;
      bit wrFlip;
      bit flip;
      bit wrFlag;
      bit flag;
   } entryT;

   logic  CLK = 1'b0;
   logic  RSTn = 1'b0;
   entryT q[$];
   int    checkCount = 0;
   int    passCount = 0;

   regs_write_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

   regs_write_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) passCount++;
      else $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
   endtask

   task automatic applyStimulus(input bit v, input bit isW, input bit isR, input int rg,
                                input int d, input bit wfl, input bit fl, input bit wfg,
                                input bit fg, input bit drn);
      bus.enq_valid   = v;
      bus.enq_isWrite = isW;
      bus.enq_isRegW  = isR;
      bus.enq_reg     = AW'(rg);
      bus.enq_data    = DW'(d);
      bus.enq_wrFlip  = wfl;
      bus.enq_flip    = fl;
      bus.enq_wrFlag  = wfg;
      bus.enq_flag    = fg;
      bus.drain_en    = drn;
   endtask

   task automatic setReads(input int r1, input bit i1, input int r2, input bit i2);
      bus.read1  = AW'(r1);
      bus.isReg1 = i1;
      bus.read2  = AW'(r2);
      bus.isReg2 = i2;
   endtask

   // Youngest pending data write visible to a reader; regular registers
   // alias modulo 4, accumulators compare the whole index.
   task automatic fwdModel(input int rd, input bit isReg, output bit hit, output int data);
      hit = 0;
      data = 0;
      foreach (q[i]) begin
         if (q[i].isWrite && q[i].isRegW == isReg &&
             (isReg ? (q[i].rg % 4) == (rd % 4) : q[i].rg == rd)) begin
            hit = 1;
            data = q[i].data;
         end
      end
   endtask

   task automatic checkAll();
      bit    drainNow;
      entryT e;
      bit    hit;
      int    data;
      bit    flipHit, flipVal, flagHit, flagVal;
      drainNow = (q.size() > 0) && bus.drain_en;
      e = '{default: 0};
      if (drainNow) e = q[0];
      checkOutput("count", bus.count, q.size());
      checkOutput("enq_ready", bus.enq_ready, q.size() < DEPTH);
      checkOutput("isWrite", bus.isWrite, e.isWrite);
      checkOutput("isRegW", bus.isRegW, e.isRegW);
      checkOutput("writeReg", bus.writeReg, e.rg);
      checkOutput("writeData", bus.writeData, e.data);
      checkOutput("writeFlip", bus.writeFlip, e.wrFlip);
      checkOutput("flipin", bus.flipin, e.flip);
      checkOutput("writeFlag", bus.writeFlag, e.wrFlag);
      checkOutput("flagin", bus.flagin, e.flag);
      fwdModel(int'(bus.read1), bus.isReg1, hit, data);
      checkOutput("fwd1_hit", bus.fwd1_hit, hit);
      checkOutput("fwd1_data", bus.fwd1_data, data);
      fwdModel(int'(bus.read2), bus.isReg2, hit, data);
      checkOutput("fwd2_hit", bus.fwd2_hit, hit);
      checkOutput("fwd2_data", bus.fwd2_data, data);
      flipHit = 0; flipVal = 0; flagHit = 0; flagVal = 0;
      foreach (q[i]) begin
         if (q[i].wrFlip) begin flipHit = 1; flipVal = q[i].flip; end
         if (q[i].wrFlag) begin flagHit = 1; flagVal = q[i].flag; end
      end
      checkOutput("fwdFlip_hit", bus.fwdFlip_hit, flipHit);
      checkOutput("fwdFlip", bus.fwdFlip, flipVal);
      checkOutput("fwdFlag_hit", bus.fwdFlag_hit, flagHit);
      checkOutput("fwdFlag", bus.fwdFlag, flagVal);
   endtask

   task automatic updateModel();
      bit    canEnq;
      entryT e;
      canEnq = q.size() < DEPTH;
      if (bus.drain_en && q.size() > 0) q.delete(0);
      if (bus.enq_valid && canEnq) begin
         e.isWrite = bus.enq_isWrite;
         e.isRegW  = bus.enq_isRegW;
         e.rg      = int'(bus.enq_reg);
         e.data    = int'(bus.enq_data);
         e.wrFlip  = bus.enq_wrFlip;
         e.flip    = bus.enq_flip;
         e.wrFlag  = bus.enq_wrFlag;
         e.flag    = bus.enq_flag;
         q.push_back(e);
      end
   endtask

   // One clock: settle, full model comparison, edge, model update, next
   // falling edge where the caller drives new inputs.
   task automatic step();
      #1;
      checkAll();
      @(posedge CLK);
      updateModel();
      @(negedge CLK);
   endtask

   task automatic idle(input bit drn);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, drn);
   endtask

   initial begin
      idle(0);
      setReads(0, 0, 0, 0);
      @(negedge CLK);
      #1;
      checkAll();
      @(negedge CLK);
      RSTn = 1'b1;

      // Single accumulator write drains on the next cycle.
      applyStimulus(1, 1, 0, 2, 'h5A, 0, 0, 0, 0, 1);
      step();
      idle(1);
      #1;
      checkOutput("first_isWrite", bus.isWrite, 1);
      checkOutput("first_isRegW", bus.isRegW, 0);
      checkOutput("first_writeReg", bus.writeReg, 2);
      checkOutput("first_writeData", bus.writeData, 'h5A);
      step();
      #1;
      checkOutput("after_isWrite", bus.isWrite, 0);
      checkOutput("after_count", bus.count, 0);
      step();

      // Fill to full with the port blocked, then drain in order.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, 1, 1, i, 'h10 + i, 0, 0, 0, 0, 0);
         step();
      end
      applyStimulus(1, 1, 1, 3, 'hEE, 0, 0, 0, 0, 0);
      #1;
      checkOutput("full_ready", bus.enq_ready, 0);
      checkOutput("full_count", bus.count, DEPTH);
      step();
      for (int i = 0; i < DEPTH; i++) begin
         idle(1);
         #1;
         checkOutput("drain_order", bus.writeData, 'h10 + i);
         step();
      end
      idle(1);
      step();

      // Forwarding picks the youngest match per bank and index rule.
      applyStimulus(1, 1, 1, 1, 'h11, 0, 0, 0, 0, 0); step();
      applyStimulus(1, 1, 0, 1, 'h22, 0, 0, 0, 0, 0); step();
      applyStimulus(1, 1, 1, 1, 'h33, 0, 0, 0, 0, 0); step();
      idle(0);
      setReads(1, 1, 1, 0);
      #1;
      checkOutput("fwd_reg1_hit", bus.fwd1_hit, 1);
      checkOutput("fwd_reg1_data", bus.fwd1_data, 'h33);
      checkOutput("fwd_acc1_data", bus.fwd2_data, 'h22);
      setReads(1, 0, 5, 0);
      #1;
      checkOutput("fwd_acc1_hit", bus.fwd1_hit, 1);
      checkOutput("fwd_acc1_via1", bus.fwd1_data, 'h22);
      checkOutput("fwd_acc5_hit", bus.fwd2_hit, 0);
      setReads(5, 1, 2, 1);
      #1;
      checkOutput("fwd_alias5_data", bus.fwd1_data, 'h33);
      step();
      for (int i = 0; i < 3; i++) begin idle(1); step(); end

      // Steady enqueue + drain across pointer wrap keeps count constant.
      applyStimulus(1, 1, 0, 4, 'hA0, 0, 0, 0, 0, 0); step();
      applyStimulus(1, 1, 0, 5, 'hA1, 0, 0, 0, 0, 0); step();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 1, 0, i % 8, 'hB0 + i, 0, 0, 0, 0, 1);
         #1;
         checkOutput("steady_count", bus.count, 2);
         step();
      end
      for (int i = 0; i < 2; i++) begin idle(1); step(); end

      // Flip/flag forwarding takes the youngest setter of each bit.
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 0); step();
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); step();
      idle(0);
      #1;
      checkOutput("flip_hit", bus.fwdFlip_hit, 1);
      checkOutput("flip_val", bus.fwdFlip, 0);
      checkOutput("flag_val", bus.fwdFlag, 1);
      step();
      for (int i = 0; i < 3; i++) begin idle(1); step(); end

      // Reset mid-cycle with entries pending discards them.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 1, i, 'hC0 + i, 1, 1, 1, 1, 0);
         step();
      end
      idle(1);
      #1;
      checkOutput("pre_reset_isWrite", bus.isWrite, 1);
      RSTn = 1'b0;
      #1;
      checkOutput("reset_isWrite", bus.isWrite, 0);
      checkOutput("reset_writeFlip", bus.writeFlip, 0);
      checkOutput("reset_count", bus.count, 0);
      checkOutput("reset_fwd1", bus.fwd1_hit, 0);
      q.delete();
      RSTn = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin idle(1); step(); end

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                       $urandom_range(0, 255), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 5);
         setReads($urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1);
         step();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
